// File: rtl/instr_decode_issue.sv
// rtl/instr_decode_issue.sv - instruction decoder with registered output stage and 1-entry skid buffer
// Optional statistics counters are built only when DECODE_STATS_EN is defined.
module instr_decode_issue #(
   parameter int BIT_WIDTH = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_iword,
   input  logic [BIT_WIDTH-1:0] in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4:0]           out_func,
   output logic [3:0]           out_rd,
   output logic [3:0]           out_rs1,
   output logic [3:0]           out_rs2,
   output logic [BIT_WIDTH-1:0] out_imm,
   output logic                 out_use_imm,
   output logic                 out_reg_we,
   output logic                 out_mem_re,
   output logic                 out_mem_we,
   output logic                 out_is_branch,
   output logic                 out_is_jal,
   output logic                 out_illegal,
   output logic [BIT_WIDTH-1:0] out_pc
`ifdef DECODE_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] stat_issued,
   output logic [CNT_WIDTH-1:0] stat_illegal
`endif
);

   typedef struct packed {
      logic [4:0]           func;
      logic [3:0]           rd;
      logic [3:0]           rs1;
      logic [3:0]           rs2;
      logic [BIT_WIDTH-1:0] imm;
      logic                 useImm;
      logic                 regWe;
      logic                 memRe;
      logic                 memWe;
      logic                 isBranch;
      logic                 isJal;
      logic                 illegal;
      logic [BIT_WIDTH-1:0] pc;
   } bundleT;

   function automatic bundleT decodeWord(input logic [31:0] iword, input logic [BIT_WIDTH-1:0] pc);
      bundleT     b;
      logic [3:0] op;
      logic [3:0] fn;
      logic       legal;
      op    = iword[3:0];
      fn    = iword[7:4];
      b     = '0;
      b.rd  = iword[31:28];
      b.rs1 = iword[27:24];
      b.rs2 = iword[23:20];
      b.pc  = pc;
      b.imm = {{(BIT_WIDTH-16){iword[23]}}, iword[23:8]};
      legal = 1'b1;
      case (op)
         4'b1100, 4'b0100: begin
            case (fn)
               4'b0000, 4'b0001, 4'b0100, 4'b0101,
               4'b0110, 4'b1100, 4'b1101, 4'b1110: legal = 1'b1;
               4'b1011: legal = (op == 4'b0100);
               default: legal = 1'b0;
            endcase
            b.func   = {1'b0, fn};
            b.regWe  = 1'b1;
            b.useImm = ~op[3];
            if (op == 4'b0100 && fn == 4'b1011)
               b.imm = BIT_WIDTH'({iword[23:8], 16'h0000});
         end
         4'b1101, 4'b0101: begin
            legal    = ~fn[2];
            b.func   = {1'b1, fn};
            b.regWe  = 1'b1;
            b.useImm = ~op[3];
         end
         4'b0110: begin
            // Branch set is the compare set plus everything except x100
            legal      = (fn[2:0] != 3'b100);
            b.func     = {1'b1, fn};
            b.isBranch = 1'b1;
         end
         4'b0111: begin
            b.useImm = 1'b1;
            b.memRe  = 1'b1;
            b.regWe  = 1'b1;
         end
         4'b0011: begin
            b.useImm = 1'b1;
            b.memWe  = 1'b1;
         end
         4'b1011: begin
            b.useImm = 1'b1;
            b.regWe  = 1'b1;
            b.isJal  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         b.func     = 5'b00000;
         b.useImm   = 1'b0;
         b.regWe    = 1'b0;
         b.memRe    = 1'b0;
         b.memWe    = 1'b0;
         b.isBranch = 1'b0;
         b.isJal    = 1'b0;
         b.illegal  = 1'b1;
      end
      return b;
   endfunction

   bundleT outReg;
   bundleT skidReg;
   bundleT decoded;
   logic   outValidReg;
   logic   skidValid;
   logic   accept;
   logic   consume;

   assign decoded = decodeWord(in_iword, in_pc);
   // in_ready depends only on the skid flop, so no combinational path from out_ready
   assign in_ready = ~skidValid;
   assign accept   = in_valid & in_ready;
   assign consume  = outValidReg & out_ready;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         outValidReg <= 1'b0;
         skidValid   <= 1'b0;
         outReg      <= '0;
         skidReg     <= '0;
      end else if (skidValid) begin
         if (consume) begin
            outReg    <= skidReg;
            skidValid <= 1'b0;
         end
      end else if (accept) begin
         if (!outValidReg || out_ready) begin
            outReg      <= decoded;
            outValidReg <= 1'b1;
         end else begin
            skidReg   <= decoded;
            skidValid <= 1'b1;
         end
      end else if (consume) begin
         outValidReg <= 1'b0;
      end
   end

   assign out_valid     = outValidReg;
   assign out_func      = outReg.func;
   assign out_rd        = outReg.rd;
   assign out_rs1       = outReg.rs1;
   assign out_rs2       = outReg.rs2;
   assign out_imm       = outReg.imm;
   assign out_use_imm   = outReg.useImm;
   assign out_reg_we    = outReg.regWe;
   assign out_mem_re    = outReg.memRe;
   assign out_mem_we    = outReg.memWe;
   assign out_is_branch = outReg.isBranch;
   assign out_is_jal    = outReg.isJal;
   assign out_illegal   = outReg.illegal;
   assign out_pc        = outReg.pc;

`ifdef DECODE_STATS_EN
   logic [CNT_WIDTH-1:0] statIssuedReg;
   logic [CNT_WIDTH-1:0] statIllegalReg;

   // Counters survive flush; only reset clears them
   always_ff @(posedge clk) begin
      if (reset) begin
         statIssuedReg  <= '0;
         statIllegalReg <= '0;
      end else if (consume) begin
         if (statIssuedReg != '1)
            statIssuedReg <= statIssuedReg + 1'b1;
         if (outReg.illegal && statIllegalReg != '1)
            statIllegalReg <= statIllegalReg + 1'b1;
      end
   end

   assign stat_issued  = statIssuedReg;
   assign stat_illegal = statIllegalReg;
`endif

endmodule

// File: tb/tb_instr_decode_issue.sv
// tb/tb_instr_decode_issue.sv - self-checking bench for instr_decode_issue
// Reference model is a queue of decoded bundles; DECODE_STATS_EN enables stats checks.
module tb_instr_decode_issue;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_iword, in_pc, out_imm, out_pc;
   logic [4:0]  out_func;
   logic [3:0]  out_rd, out_rs1, out_rs2;
   logic        out_use_imm, out_reg_we, out_mem_re, out_mem_we, out_is_branch, out_is_jal, out_illegal;
`ifdef DECODE_STATS_EN
   logic [15:0] stat_issued, stat_illegal;
`endif

   always #5 clk = ~clk;

   instr_decode_issue #(.BIT_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_iword(in_iword), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
      .out_use_imm(out_use_imm), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
      .out_mem_we(out_mem_we), .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
      .out_illegal(out_illegal), .out_pc(out_pc)
`ifdef DECODE_STATS_EN
      , .stat_issued(stat_issued), .stat_illegal(stat_illegal)
`endif
   );

   typedef struct packed {
      logic [4:0]  func;
      logic [3:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        useImm, regWe, memRe, memWe, isBranch, isJal, illegal;
      logic [31:0] pc;
   } bundleT;

   bundleT      q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned mIssued = 0;
   int unsigned mIllegal = 0;

   function automatic bundleT refDecode(input logic [31:0] w, input logic [31:0] pc);
      bundleT     b;
      logic [3:0] op, fn;
      logic       legal, aluSet, cmpSet, brSet;
      op = w[3:0];
      fn = w[7:4];
      aluSet = fn inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd12, 4'd13, 4'd14};
      cmpSet = fn inside {[4'd0:4'd3], [4'd8:4'd11]};
      brSet  = cmpSet || (fn inside {4'd5, 4'd6, 4'd7, 4'd13, 4'd14, 4'd15});
      b = '0;
      b.rd = w[31:28]; b.rs1 = w[27:24]; b.rs2 = w[23:20]; b.pc = pc;
      b.imm = {{16{w[23]}}, w[23:8]};
      legal = 1'b1;
      if (op == 4'hC) begin
         legal = aluSet; b.func = {1'b0, fn}; b.regWe = 1'b1;
      end else if (op == 4'h4) begin
         legal = aluSet || fn == 4'd11; b.func = {1'b0, fn}; b.regWe = 1'b1; b.useImm = 1'b1;
         if (fn == 4'd11) b.imm = {w[23:8], 16'h0000};
      end else if (op == 4'hD || op == 4'h5) begin
         legal = cmpSet; b.func = {1'b1, fn}; b.regWe = 1'b1; b.useImm = (op == 4'h5);
      end else if (op == 4'h6) begin
         legal = brSet; b.func = {1'b1, fn}; b.isBranch = 1'b1;
      end else if (op == 4'h7) begin
         b.useImm = 1'b1; b.memRe = 1'b1; b.regWe = 1'b1;
      end else if (op == 4'h3) begin
         b.useImm = 1'b1; b.memWe = 1'b1;
      end else if (op == 4'hB) begin
         b.useImm = 1'b1; b.regWe = 1'b1; b.isJal = 1'b1;
      end else begin
         legal = 1'b0;
      end
      if (!legal) begin
         b.func = 5'd0; b.regWe = 1'b0; b.memRe = 1'b0; b.memWe = 1'b0;
         b.isBranch = 1'b0; b.isJal = 1'b0; b.useImm = 1'b0; b.illegal = 1'b1;
      end
      return b;
   endfunction

   // use_imm/imm are not defined for illegal bundles, so they are excluded there
   function automatic bundleT maskIll(input bundleT b);
      bundleT m;
      m = b;
      if (m.illegal) begin
         m.useImm = 1'b0;
         m.imm = 32'd0;
      end
      return m;
   endfunction

   function automatic bundleT observed();
      bundleT b;
      b = {out_func, out_rd, out_rs1, out_rs2, out_imm, out_use_imm, out_reg_we, out_mem_re,
           out_mem_we, out_is_branch, out_is_jal, out_illegal, out_pc};
      return b;
   endfunction

   function automatic logic [31:0] randWord();
      logic [31:0] w;
      logic [3:0]  ops [10];
      ops = '{4'hC, 4'h4, 4'hD, 4'h5, 4'h6, 4'h7, 4'h3, 4'hB, 4'hF, 4'h0};
      w = $urandom;
      w[3:0] = ops[$urandom_range(0, 9)];
      return w;
   endfunction

   task automatic tick();
      logic   acc, con;
      bundleT nb;
      acc = in_valid && (q.size() < 2);
      con = out_ready && (q.size() > 0);
      nb  = refDecode(in_iword, in_pc);
      @(posedge clk);
      if (reset) begin
         q.delete(); mIssued = 0; mIllegal = 0;
      end else begin
         if (con) begin
            if (mIssued < 65535) mIssued++;
            if (q[0].illegal && mIllegal < 65535) mIllegal++;
         end
         if (flush) q.delete();
         else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(nb);
         end
      end
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++;
      if (observed() !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", observed()); end
   endtask

   task automatic test_directed();
      logic [31:0] words [4];
      logic [47:0] expv [4];
      logic [47:0] got;
      // {func, imm, use_imm, reg_we, is_branch, rd} expected for ADD, MVHI, ADDI -2, BLT
      words = '{32'h3120_000C, 32'h50AB_CDB4, 32'h12FF_FE04, 32'h0012_3426};
      expv  = '{{5'b00000, 32'h0000_2000, 1'b0, 1'b1, 1'b0, 4'd3},
                {5'b01011, 32'hABCD_0000, 1'b1, 1'b1, 1'b0, 4'd5},
                {5'b00000, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 4'd1},
                {5'b10010, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 4'd0}};
      doReset();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_iword = words[k]; in_pc = $urandom;
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_%0d out_valid got=%b want=1", k, out_valid); end
         got = {out_func, out_imm, out_use_imm, out_reg_we, out_is_branch, out_rd};
         checks++;
         if (got !== expv[k]) begin errors++; $display("FAIL directed_%0d got=%h want=%h", k, got, expv[k]); end
         checks++;
         if (q.size() == 0 || observed() !== q[0]) begin errors++; $display("FAIL directed_model_%0d got=%h", k, observed()); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] words [3];
      logic [31:0] gotPc [$];
      int          idx;
      doReset();
      for (int k = 0; k < 3; k++) words[k] = randWord();
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_iword = words[idx]; in_pc = idx;
         if (q.size() < 2) idx++;
         tick();
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0) begin errors++; $display("FAIL bp_hold valid=%b pc=%0d want 1/0", out_valid, out_pc); end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (idx < 3) begin in_valid = 1'b1; in_iword = words[idx]; in_pc = idx; end
         else in_valid = 1'b0;
         if (in_valid && q.size() < 2) idx++;
         if (out_valid && out_ready) gotPc.push_back(out_pc);
         tick();
      end
      checks++;
      if (gotPc.size() != 3 || gotPc[0] !== 32'd0 || gotPc[1] !== 32'd1 || gotPc[2] !== 32'd2)
         begin errors++; $display("FAIL bp_order count=%0d want=3 in order 0,1,2", gotPc.size()); end
   endtask

   task automatic test_illegal();
      logic [31:0] words [2];
      logic [6:0]  got;
      words = '{32'h1234_567F, 32'h3120_002C};
      doReset();
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_iword = words[k]; in_pc = k;
         tick();
         got = {out_illegal, out_func, out_reg_we};
         checks++;
         if (got !== 7'b1_00000_0 || {out_mem_re, out_mem_we, out_is_branch, out_is_jal} !== 4'b0)
            begin errors++; $display("FAIL illegal_%0d got=%b want=1000000", k, got); end
      end
      in_valid = 1'b0;
      tick();
`ifdef DECODE_STATS_EN
      checks++;
      if (stat_illegal !== 16'd2) begin errors++; $display("FAIL stat_illegal got=%0d want=2", stat_illegal); end
      checks++;
      if (stat_issued !== 16'd2) begin errors++; $display("FAIL stat_issued got=%0d want=2", stat_issued); end
`endif
   endtask

   task automatic test_flush();
      doReset();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_iword = randWord(); in_pc = k;
         tick();
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full in_ready got=%b want=0", in_ready); end
      flush = 1'b1; in_valid = 1'b1; in_iword = 32'h3120_000C;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush valid=%b ready=%b want 0/1", out_valid, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop out_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      doReset();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_iword = randWord(); in_pc = $urandom;
         tick();
      end
      reset = 1'b1; flush = 1'b1;
      tick();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0)
         begin errors++; $display("FAIL reset_mid valid=%b ready=%b data=%h want 0/1/0", out_valid, in_ready, observed()); end
`ifdef DECODE_STATS_EN
      checks++;
      if (stat_issued !== 16'd0 || stat_illegal !== 16'd0) begin errors++; $display("FAIL reset_mid_stats got=%0d/%0d want 0/0", stat_issued, stat_illegal); end
`endif
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 96) == 0);
         in_iword  = randWord();
         in_pc     = $urandom;
         tick();
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2))
            begin errors++; $display("FAIL rand_hs cyc=%0d valid=%b ready=%b entries=%0d", c, out_valid, in_ready, q.size()); end
         if (q.size() > 0) begin
            checks++;
            if (maskIll(observed()) !== maskIll(q[0]))
               begin errors++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, observed(), q[0]); end
         end
`ifdef DECODE_STATS_EN
         checks++;
         if (stat_issued !== 16'(mIssued) || stat_illegal !== 16'(mIllegal))
            begin errors++; $display("FAIL rand_stats cyc=%0d got=%0d/%0d want=%0d/%0d", c, stat_issued, stat_illegal, mIssued, mIllegal); end
`endif
      end
      flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_iword = 32'd0; in_pc = 32'd0;
      #1;
      test_reset();
      test_directed();
      test_backpressure();
      test_illegal();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
